// File: rtl/jt12_pg_pkg.sv
// Shared constants and slot decode for the phase-generator slot sequencer.
// Slot order within a round: groups of six channels, operators S1,S3,S2,S4.
package jt12_pg_pkg;

  localparam int SLOTS = 24;
  localparam int CHANS = 6;

  localparam int FNUM_LSB  = 0;
  localparam int FNUM_W    = 11;
  localparam int BLOCK_LSB = 11;
  localparam int BLOCK_W   = 3;
  localparam int MUL_LSB   = 0;
  localparam int MUL_W     = 4;
  localparam int DT1_LSB   = 4;
  localparam int DT1_W     = 3;

  // Operator index (0..3 = S1..S4) served by each six-slot group.
  localparam logic [1:0] OP_ORDER [4] = '{2'd0, 2'd2, 2'd1, 2'd3};

  typedef struct packed {
    logic [2:0] ch;
    logic [1:0] op;
  } chop_t;

  function automatic chop_t slot_to_chop(input logic [4:0] slot);
    chop_t r;
    r.ch = 3'(slot % 5'd6);
    r.op = OP_ORDER[2'(slot / 5'd6)];
    return r;
  endfunction

endpackage

// File: rtl/jt12_pg_slotmap.sv
// Combinational slot index to {channel, operator} decode.
module jt12_pg_slotmap
  import jt12_pg_pkg::*;
(
  input  logic [4:0] slot_i,
  output logic [2:0] ch_o,
  output logic [1:0] op_o
);

  chop_t map;

  assign map  = slot_to_chop(slot_i);
  assign ch_o = map.ch;
  assign op_o = map.op;

endmodule

// File: rtl/jt12_pg_sched.sv
// Slot sequencer and parameter feeder for the 24-slot PG pipeline: register files,
// one-entry write buffer committed at the round boundary, key-on to phase-reset pulses.
module jt12_pg_sched
  import jt12_pg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic        wr_sel,
  input  logic [2:0]  wr_ch,
  input  logic [1:0]  wr_op,
  input  logic [13:0] wr_data,
  input  logic        kon_valid,
  input  logic [2:0]  kon_ch,
  input  logic [3:0]  kon_ops,
  output logic        zero,
  output logic [4:0]  slot_I,
  output logic [10:0] fnum_I,
  output logic [2:0]  block_I,
  output logic [2:0]  dt1_II,
  output logic        pg_rst_III,
  output logic [3:0]  mul_V
);

  logic [4:0]  slot_i_q, slot_ii_q, slot_iii_q, slot_iv_q;
  logic [4:0]  slot_d;
  logic        zero_q;
  logic [10:0] fnum_o_q;
  logic [2:0]  block_o_q;
  logic [2:0]  dt1_o_q;
  logic        pg_rst_o_q;
  logic [3:0]  mul_o_q;

  logic [10:0] fnum_q  [CHANS];
  logic [2:0]  block_q [CHANS];
  logic [2:0]  dt1_q   [CHANS][4];
  logic [3:0]  mul_q   [CHANS][4];
  logic [3:0]  kon_q   [CHANS];
  logic [3:0]  kon_d   [CHANS];

  logic        wr_ready_q;
  logic        pend_sel_q;
  logic [2:0]  pend_ch_q;
  logic [1:0]  pend_op_q;
  logic [13:0] pend_dat_q;
  logic        accept;
  logic        commit;

  logic [2:0]  ch_i, ch_ii, ch_iii, ch_v;
  logic [1:0]  op_i, op_ii, op_iii, op_v;

  assign slot_d = (slot_i_q == 5'(SLOTS - 1)) ? 5'd0 : slot_i_q + 5'd1;
  assign accept = wr_valid && wr_ready_q;
  assign commit = clk_en && (slot_i_q == 5'(SLOTS - 1)) && !wr_ready_q;

  // Each tap decodes the slot that is about to enter that stage on this edge.
  jt12_pg_slotmap u_map_i   (.slot_i(slot_d),    .ch_o(ch_i),   .op_o(op_i));
  jt12_pg_slotmap u_map_ii  (.slot_i(slot_i_q),  .ch_o(ch_ii),  .op_o(op_ii));
  jt12_pg_slotmap u_map_iii (.slot_i(slot_ii_q), .ch_o(ch_iii), .op_o(op_iii));
  jt12_pg_slotmap u_map_v   (.slot_i(slot_iv_q), .ch_o(ch_v),   .op_o(op_v));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_i_q   <= 5'd23;
      slot_ii_q  <= 5'd22;
      slot_iii_q <= 5'd21;
      slot_iv_q  <= 5'd20;
      zero_q     <= 1'b0;
      fnum_o_q   <= '0;
      block_o_q  <= '0;
      dt1_o_q    <= '0;
      pg_rst_o_q <= 1'b0;
      mul_o_q    <= '0;
    end else if (clk_en) begin
      slot_i_q   <= slot_d;
      slot_ii_q  <= slot_i_q;
      slot_iii_q <= slot_ii_q;
      slot_iv_q  <= slot_iii_q;
      zero_q     <= (slot_d == 5'd0);
      fnum_o_q   <= fnum_q[ch_i];
      block_o_q  <= block_q[ch_i];
      dt1_o_q    <= dt1_q[ch_ii][op_ii];
      pg_rst_o_q <= kon_q[ch_iii][op_iii];
      mul_o_q    <= mul_q[ch_v][op_v];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ready_q <= 1'b1;
      pend_sel_q <= 1'b0;
      pend_ch_q  <= '0;
      pend_op_q  <= '0;
      pend_dat_q <= '0;
    end else if (accept) begin
      wr_ready_q <= 1'b0;
      pend_sel_q <= wr_sel;
      pend_ch_q  <= wr_ch;
      pend_op_q  <= wr_op;
      pend_dat_q <= wr_data;
    end else if (commit) begin
      wr_ready_q <= 1'b1;
    end
  end

  // Committed contents are visible only to loads on later edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANS; c++) begin
        fnum_q[c]  <= '0;
        block_q[c] <= '0;
        for (int o = 0; o < 4; o++) begin
          dt1_q[c][o] <= '0;
          mul_q[c][o] <= '0;
        end
      end
    end else if (commit && (pend_ch_q < 3'(CHANS))) begin
      if (!pend_sel_q) begin
        fnum_q[pend_ch_q]  <= pend_dat_q[FNUM_LSB +: FNUM_W];
        block_q[pend_ch_q] <= pend_dat_q[BLOCK_LSB +: BLOCK_W];
      end else begin
        dt1_q[pend_ch_q][pend_op_q] <= pend_dat_q[DT1_LSB +: DT1_W];
        mul_q[pend_ch_q][pend_op_q] <= pend_dat_q[MUL_LSB +: MUL_W];
      end
    end
  end

  // Clear of the slot entering stage III is applied first so a same-edge set wins.
  always_comb begin
    for (int c = 0; c < CHANS; c++) kon_d[c] = kon_q[c];
    if (clk_en) kon_d[ch_iii][op_iii] = 1'b0;
    if (kon_valid && (kon_ch < 3'(CHANS))) kon_d[kon_ch] = kon_d[kon_ch] | kon_ops;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANS; c++) kon_q[c] <= '0;
    end else begin
      for (int c = 0; c < CHANS; c++) kon_q[c] <= kon_d[c];
    end
  end

  assign wr_ready   = wr_ready_q;
  assign zero       = zero_q;
  assign slot_I     = slot_i_q;
  assign fnum_I     = fnum_o_q;
  assign block_I    = block_o_q;
  assign dt1_II     = dt1_o_q;
  assign pg_rst_III = pg_rst_o_q;
  assign mul_V      = mul_o_q;

endmodule

// File: tb/tb_jt12_pg_sched.sv
// Scoreboard bench for jt12_pg_sched: stimulus pushes expected outputs per clk_en edge,
// a monitor pops and compares after each such edge.
module tb_jt12_pg_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_en;
  logic        wr_valid;
  logic        wr_ready;
  logic        wr_sel;
  logic [2:0]  wr_ch;
  logic [1:0]  wr_op;
  logic [13:0] wr_data;
  logic        kon_valid;
  logic [2:0]  kon_ch;
  logic [3:0]  kon_ops;
  logic        zero;
  logic [4:0]  slot_I;
  logic [10:0] fnum_I;
  logic [2:0]  block_I;
  logic [2:0]  dt1_II;
  logic        pg_rst_III;
  logic [3:0]  mul_V;

  always #5 clk = ~clk;

  jt12_pg_sched dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel), .wr_ch(wr_ch),
    .wr_op(wr_op), .wr_data(wr_data),
    .kon_valid(kon_valid), .kon_ch(kon_ch), .kon_ops(kon_ops),
    .zero(zero), .slot_I(slot_I), .fnum_I(fnum_I), .block_I(block_I),
    .dt1_II(dt1_II), .pg_rst_III(pg_rst_III), .mul_V(mul_V)
  );

  typedef struct packed {
    logic [4:0]  slot;
    logic        zero;
    logic [10:0] fnum;
    logic [2:0]  block;
    logic [2:0]  dt1;
    logic        pg;
    logic [3:0]  mul;
    logic        rdy;
  } out_t;

  out_t exp_q[$];
  out_t m_out;
  int   n_chk = 0;
  int   n_pass = 0;

  // Reference state: slot order S1,S3,S2,S4 per group; op n sits in group ORD[n].
  int          ORD [4] = '{0, 2, 1, 3};
  int          m_slot;
  logic [10:0] m_fnum [6];
  logic [2:0]  m_block [6];
  logic [2:0]  m_dt1 [6][4];
  logic [3:0]  m_mul [6][4];
  logic        m_kon [24];
  logic        m_pend;
  logic        m_psel;
  logic [2:0]  m_pch;
  logic [1:0]  m_pop;
  logic [13:0] m_pdat;

  logic en_seen = 1'b0;
  logic snap_seen = 1'b0;
  logic snap;

  always @(posedge clk) begin
    en_seen   <= clk_en;
    snap_seen <= snap;
  end

  always @(negedge clk) begin : monitor
    out_t act;
    out_t e;
    if (en_seen || snap_seen) begin
      act = {slot_I, zero, fnum_I, block_I, dt1_II, pg_rst_III, mul_V, wr_ready};
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_output act=%h (no expected entry queued)", act);
      end else begin
        e = exp_q.pop_front();
        if (act === e) n_pass++;
        else $display("FAIL outputs slot=%0d act{slot,zero,fnum,block,dt1,pg,mul,rdy}=%0d,%0b,%h,%0d,%0d,%0b,%0d,%0b exp=%0d,%0b,%h,%0d,%0d,%0b,%0d,%0b",
                      e.slot, act.slot, act.zero, act.fnum, act.block, act.dt1, act.pg, act.mul, act.rdy,
                      e.slot, e.zero, e.fnum, e.block, e.dt1, e.pg, e.mul, e.rdy);
      end
    end
  end

  task automatic model_reset();
    m_slot = 23;
    for (int c = 0; c < 6; c++) begin
      m_fnum[c] = '0; m_block[c] = '0;
      for (int o = 0; o < 4; o++) begin m_dt1[c][o] = '0; m_mul[c][o] = '0; end
    end
    for (int s = 0; s < 24; s++) m_kon[s] = 1'b0;
    m_pend = 1'b0;
    m_out = '{slot: 5'd23, zero: 1'b0, fnum: '0, block: '0, dt1: '0, pg: 1'b0, mul: '0, rdy: 1'b1};
  endtask

  task automatic kon_model(input logic [2:0] c, input logic [3:0] o);
    if (c < 3'd6)
      for (int n = 0; n < 4; n++)
        if (o[n]) m_kon[ORD[n] * 6 + int'(c)] = 1'b1;
  endtask

  task automatic tick(input bit kv, input logic [2:0] kc, input logic [3:0] ko);
    int ns, s2, s3, s5;
    out_t e;
    ns = (m_slot == 23) ? 0 : m_slot + 1;
    s2 = (ns + 23) % 24;
    s3 = (ns + 22) % 24;
    s5 = (ns + 20) % 24;
    e.slot  = 5'(ns);
    e.zero  = (ns == 0);
    e.fnum  = m_fnum[ns % 6];
    e.block = m_block[ns % 6];
    e.dt1   = m_dt1[s2 % 6][ORD[s2 / 6]];
    e.mul   = m_mul[s5 % 6][ORD[s5 / 6]];
    e.pg    = m_kon[s3];
    m_kon[s3] = 1'b0;
    if (kv) kon_model(kc, ko);
    if (ns == 0 && m_pend) begin
      if (m_pch < 3'd6) begin
        if (!m_psel) {m_block[m_pch], m_fnum[m_pch]} = m_pdat;
        else {m_dt1[m_pch][m_pop], m_mul[m_pch][m_pop]} = m_pdat[6:0];
      end
      m_pend = 1'b0;
    end
    e.rdy  = !m_pend;
    m_slot = ns;
    m_out  = e;
    exp_q.push_back(e);
    clk_en = 1'b1; kon_valid = kv; kon_ch = kc; kon_ops = ko;
    @(negedge clk);
    clk_en = 1'b0; kon_valid = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 3'd0, 4'd0);
  endtask

  task automatic do_wr(input logic s, input logic [2:0] c, input logic [1:0] o, input logic [13:0] d);
    wr_valid = 1'b1; wr_sel = s; wr_ch = c; wr_op = o; wr_data = d;
    @(negedge clk);
    wr_valid = 1'b0;
    m_pend = 1'b1; m_psel = s; m_pch = c; m_pop = o; m_pdat = d;
    m_out.rdy = 1'b0;
  endtask

  task automatic do_kon(input logic [2:0] c, input logic [3:0] o);
    kon_valid = 1'b1; kon_ch = c; kon_ops = o;
    @(negedge clk);
    kon_valid = 1'b0;
    kon_model(c, o);
  endtask

  task automatic snapshot();
    exp_q.push_back(m_out);
    snap = 1'b1;
    @(negedge clk);
    snap = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    clk_en = 0; wr_valid = 0; wr_sel = 0; wr_ch = 0; wr_op = 0; wr_data = 0;
    kon_valid = 0; kon_ch = 0; kon_ops = 0; snap = 0; rst_n = 1'b1;
    @(negedge clk);
    do_reset();
    snapshot();
    ticks(24);

    // Channel-2 frequency write issued mid-round; visible only after the 23->0 edge.
    ticks(6);
    do_wr(1'b0, 3'd2, 2'd0, {3'd4, 11'h2A5});
    repeat (3) @(negedge clk);
    snapshot();
    ticks(48);

    // Operator write ch0 S2: dt1=5, mul=3 lands on slot 12.
    do_wr(1'b1, 3'd0, 2'd1, {7'b0, 3'd5, 4'd3});
    ticks(48);

    // Key-on ch1 S1+S4 -> stage-III pulses at slots 1 and 19, repeated next round.
    do_kon(3'd1, 4'b1001);
    ticks(24);
    do_kon(3'd1, 4'b1001);
    ticks(24);

    // Re-arm on the very edge the bit clears: pulse now and again a round later.
    do_kon(3'd1, 4'b0001);
    for (int i = 0; i < 24 && m_slot != 2; i++) tick(1'b0, 3'd0, 4'd0);
    tick(1'b1, 3'd1, 4'b0001);
    ticks(26);

    // Channel 6 write is handshaken but dropped.
    do_wr(1'b0, 3'd6, 2'd0, 14'h3FFF);
    ticks(30);

    // Reset with a pending write and pending key-ons discards both.
    ticks(5);
    do_wr(1'b0, 3'd3, 2'd0, 14'h1234);
    do_kon(3'd2, 4'b1111);
    snapshot();
    do_reset();
    snapshot();
    ticks(30);

    repeat (3) @(negedge clk);
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
